// File: rtl/coin_eject_sequencer.sv
// Coin eject sequencer: takes one change vector per vend and pulses the tube
// solenoids one coin at a time, quarters first, with an empty-tube abort path.
module coin_eject_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] quarters,
    input  logic [2:0] dimes,
    input  logic [2:0] nickels,
    input  logic [2:0] pennies,
    input  logic [3:0] tube_empty,
    input  logic       fault_clr,
    output logic [3:0] eject,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_coin,
    output logic [5:0] coins_left
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] COIN_Q = 2'd3;
    localparam logic [1:0] COIN_D = 2'd2;
    localparam logic [1:0] COIN_N = 2'd1;
    localparam logic [1:0] COIN_P = 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state;
    logic [3:0]       q_cnt;
    logic [2:0]       d_cnt;
    logic [2:0]       n_cnt;
    logic [2:0]       p_cnt;
    logic [1:0]       sel;
    logic [CNT_W-1:0] timer;
    logic [1:0]       pick;
    logic [5:0]       in_total;

    function automatic logic [3:0] coin_mask(input logic [1:0] coin);
        return 4'b0001 << coin;
    endfunction

    // Highest remaining denomination; only meaningful while some count is nonzero.
    always_comb begin
        pick = COIN_P;
        if (q_cnt != 4'd0) begin
            pick = COIN_Q;
        end else if (d_cnt != 3'd0) begin
            pick = COIN_D;
        end else if (n_cnt != 3'd0) begin
            pick = COIN_N;
        end
    end

    assign in_total = 6'(quarters) + 6'(dimes) + 6'(nickels) + 6'(pennies);

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            q_cnt      <= 4'd0;
            d_cnt      <= 3'd0;
            n_cnt      <= 3'd0;
            p_cnt      <= 3'd0;
            sel        <= COIN_P;
            timer      <= '0;
            eject      <= 4'b0000;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_coin <= 2'd0;
            coins_left <= 6'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        q_cnt      <= quarters;
                        d_cnt      <= dimes;
                        n_cnt      <= nickels;
                        p_cnt      <= pennies;
                        coins_left <= in_total;
                        if (in_total == 6'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end

                S_SELECT: begin
                    sel <= pick;
                    if (tube_empty[pick]) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_coin <= pick;
                        q_cnt      <= 4'd0;
                        d_cnt      <= 3'd0;
                        n_cnt      <= 3'd0;
                        p_cnt      <= 3'd0;
                        coins_left <= 6'd0;
                    end else begin
                        state <= S_PULSE;
                        timer <= PULSE_LOAD;
                        eject <= coin_mask(pick);
                    end
                end

                S_PULSE: begin
                    if (timer == '0) begin
                        // Coin is committed once its pulse completes.
                        state      <= S_GAP;
                        timer      <= GAP_LOAD;
                        eject      <= 4'b0000;
                        coins_left <= coins_left - 6'd1;
                        case (sel)
                            COIN_Q:  q_cnt <= q_cnt - 4'd1;
                            COIN_D:  d_cnt <= d_cnt - 3'd1;
                            COIN_N:  n_cnt <= n_cnt - 3'd1;
                            default: p_cnt <= p_cnt - 3'd1;
                        endcase
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_GAP: begin
                    if (timer == '0) begin
                        if (coins_left == 6'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                S_FAULT: begin
                    // A vector presented alongside the clear is deliberately dropped.
                    if (fault_clr) begin
                        state      <= S_IDLE;
                        fault      <= 1'b0;
                        fault_coin <= 2'd0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    eject <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_eject_sequencer.sv
// Bench for coin_eject_sequencer: two instances (short and default timing) checked
// every cycle against a coin-schedule model, plus directed literal scenarios.
module tb_coin_eject_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] fault_clr;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] fault;
    logic [3:0] quarters   [2];
    logic [2:0] dimes      [2];
    logic [2:0] nickels    [2];
    logic [2:0] pennies    [2];
    logic [3:0] tube_empty [2];
    logic [3:0] eject      [2];
    logic [1:0] fault_coin [2];
    logic [5:0] coins_left [2];

    int n_checks;
    int n_errors;

    // Model: the payout is a list of coins in dispense order; each coin owns
    // a slot of 1 + P + G cycles (select, pulse, gap). ph is the slot offset.
    int mode [2];   // 0 idle, 1 paying, 2 done cycle, 3 faulted
    int ph   [2];
    int seq  [2][36];
    int head [2];
    int len  [2];
    int fc   [2];
    int fc_known [2];

    int t1_ej [17] = '{0, 8, 8, 0, 0, 4, 4, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    int t1_cl [17] = '{4, 4, 4, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};

    coin_eject_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .quarters(quarters[0]), .dimes(dimes[0]), .nickels(nickels[0]), .pennies(pennies[0]),
        .tube_empty(tube_empty[0]), .fault_clr(fault_clr[0]), .eject(eject[0]),
        .busy(busy[0]), .done(done[0]), .fault(fault[0]), .fault_coin(fault_coin[0]),
        .coins_left(coins_left[0])
    );

    coin_eject_sequencer dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .quarters(quarters[1]), .dimes(dimes[1]), .nickels(nickels[1]), .pennies(pennies[1]),
        .tube_empty(tube_empty[1]), .fault_clr(fault_clr[1]), .eject(eject[1]),
        .busy(busy[1]), .done(done[1]), .fault(fault[1]), .fault_coin(fault_coin[1]),
        .coins_left(coins_left[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pw(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int gw(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s[inst %0d] t=%0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; ph[i] = 0; head[i] = 0; len[i] = 0;
            fc[i] = 0; fc_known[i] = 1;
        end
    endtask

    task automatic model_step(input int i);
        case (mode[i])
            0: if (in_valid[i]) begin
                head[i] = 0;
                len[i]  = 0;
                for (int k = 0; k < int'(quarters[i]); k++) begin seq[i][len[i]] = 3; len[i]++; end
                for (int k = 0; k < int'(dimes[i]); k++)    begin seq[i][len[i]] = 2; len[i]++; end
                for (int k = 0; k < int'(nickels[i]); k++)  begin seq[i][len[i]] = 1; len[i]++; end
                for (int k = 0; k < int'(pennies[i]); k++)  begin seq[i][len[i]] = 0; len[i]++; end
                mode[i] = (len[i] == 0) ? 2 : 1;
                ph[i]   = 0;
            end
            1: begin
                if (ph[i] == 0) begin
                    if (tube_empty[i][seq[i][head[i]]]) begin
                        mode[i] = 3; fc[i] = seq[i][head[i]]; fc_known[i] = 1;
                        head[i] = len[i];
                    end else begin
                        ph[i] = 1;
                    end
                end else if (ph[i] <= pw(i)) begin
                    if (ph[i] == pw(i)) head[i]++;
                    ph[i]++;
                end else if (ph[i] == pw(i) + gw(i)) begin
                    if (head[i] == len[i]) mode[i] = 2;
                    else ph[i] = 0;
                end else begin
                    ph[i]++;
                end
            end
            2: mode[i] = 0;
            default: if (fault_clr[i]) begin mode[i] = 0; fc_known[i] = 0; end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [3:0] exp_ej;
                exp_ej = 4'b0000;
                if (mode[i] == 1 && ph[i] >= 1 && ph[i] <= pw(i))
                    exp_ej = 4'b0001 << seq[i][head[i]];
                chk("in_ready", i, in_ready[i], mode[i] == 0);
                chk("busy", i, busy[i], mode[i] != 0);
                chk("done", i, done[i], mode[i] == 2);
                chk("fault", i, fault[i], mode[i] == 3);
                chk("eject", i, eject[i], exp_ej);
                chk("eject_onehot", i, $countones(eject[i]) <= 1, 1);
                chk("coins_left", i, coins_left[i], len[i] - head[i]);
                if (fc_known[i] != 0) chk("fault_coin", i, fault_coin[i], fc[i]);
            end
        end
    end

    task automatic set_vec(input int i, input int q, input int d, input int n, input int p);
        quarters[i] = 4'(q);
        dimes[i]    = 3'(d);
        nickels[i]  = 3'(n);
        pennies[i]  = 3'(p);
    endtask

    // Presents a vector so it is accepted at the next edge (edge 0); returns just after it.
    task automatic start(input int i, input int q, input int d, input int n, input int p);
        @(posedge clk);
        #1;
        set_vec(i, q, d, n, p);
        in_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (!in_ready[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", i, in_ready[i], 1);
    endtask

    function automatic int coin_of(input logic [3:0] e);
        if (e[3]) return 3;
        if (e[2]) return 2;
        if (e[1]) return 1;
        return 0;
    endfunction

    initial begin
        int pulses;
        int done_seen;
        logic [3:0] prev;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in_valid = 2'b00;
        fault_clr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            set_vec(i, 0, 0, 0, 0);
            tube_empty[i] = 4'b0000;
        end
        repeat (3) @(negedge clk);
        chk("rst_eject", 1, eject[1], 0);
        chk("rst_in_ready", 1, in_ready[1], 1);
        chk("rst_coins_left", 1, coins_left[1], 0);
        #1 rst_n = 1'b1;

        // 37 cents on the short-timing instance.
        start(0, 1, 1, 0, 2);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk("t1_eject", 0, eject[0], t1_ej[c-1]);
            chk("t1_coins_left", 0, coins_left[0], t1_cl[c-1]);
            chk("t1_done", 0, done[0], c == 17);
        end
        wait_idle(0, 10);

        // Zero change.
        start(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_done", 1, done[1], 1);
        chk("t2_busy", 1, busy[1], 1);
        chk("t2_eject", 1, eject[1], 0);
        @(negedge clk);
        chk("t2_done_after", 1, done[1], 0);
        chk("t2_busy_after", 1, busy[1], 0);

        // Dime tube empties after the first quarter.
        start(1, 2, 1, 0, 0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 6) tube_empty[1] = 4'b0100;
            if (c == 2 || c == 9) chk("t3_quarter", 1, eject[1], 8);
            if (c == 15) chk("t3_fault_early", 1, fault[1], 0);
            if (c >= 16) begin
                chk("t3_fault", 1, fault[1], 1);
                chk("t3_fault_coin", 1, fault_coin[1], 2);
                chk("t3_eject", 1, eject[1], 0);
            end
            chk("t3_no_done", 1, done[1], 0);
        end
        @(posedge clk);
        #1;
        fault_clr[1] = 1'b1;
        in_valid[1] = 1'b1;
        set_vec(1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        fault_clr[1] = 1'b0;
        in_valid[1] = 1'b0;
        tube_empty[1] = 4'b0000;
        @(negedge clk);
        chk("t3_cleared_ready", 1, in_ready[1], 1);
        chk("t3_cleared_fault", 1, fault[1], 0);
        @(negedge clk);
        chk("t3_vector_dropped", 1, busy[1], 0);

        // Full load with default timing.
        start(1, 15, 7, 7, 7);
        pulses = 0;
        done_seen = 0;
        prev = 4'b0000;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk);
            if (c == 1) chk("t4_coins_left", 1, coins_left[1], 36);
            if (eject[1] != 4'b0000 && prev == 4'b0000) begin
                chk("t4_order", 1, coin_of(eject[1]),
                    (pulses < 15) ? 3 : (pulses < 22) ? 2 : (pulses < 29) ? 1 : 0);
                pulses++;
            end
            if (done[1]) begin
                chk("t4_done_cycle", 1, c, 253);
                done_seen++;
            end
            prev = eject[1];
        end
        chk("t4_pulses", 1, pulses, 36);
        chk("t4_done_count", 1, done_seen, 1);

        // Reset during the second coin's pulse.
        start(1, 2, 0, 0, 0);
        for (int c = 1; c <= 10; c++) @(negedge clk);
        chk("t5_pre_eject", 1, eject[1], 8);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_eject_async", 1, eject[1], 0);
        chk("t5_busy", 1, busy[1], 0);
        chk("t5_in_ready", 1, in_ready[1], 1);
        chk("t5_coins_left", 1, coins_left[1], 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        start(1, 0, 1, 1, 0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk("t5_done", 1, done[1], c == 15);
        end

        // in_valid held high across a whole payout.
        @(posedge clk);
        #1;
        set_vec(1, 0, 1, 0, 0);
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        set_vec(1, 1, 0, 0, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c < 8) chk("t6_ready_low", 1, in_ready[1], 0);
            if (c == 8) chk("t6_done", 1, done[1], 1);
            if (c == 9) chk("t6_ready_idle", 1, in_ready[1], 1);
            if (c == 10) begin
                chk("t6_accepted", 1, busy[1], 1);
                chk("t6_coins_left", 1, coins_left[1], 2);
            end
        end
        in_valid[1] = 1'b0;
        wait_idle(1, 100);

        // Random traffic on both instances.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) == 0);
                fault_clr[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0)
                    set_vec(i, $urandom_range(0, 15), $urandom_range(0, 7),
                            $urandom_range(0, 7), $urandom_range(0, 7));
                else
                    set_vec(i, $urandom_range(0, 2), $urandom_range(0, 2),
                            $urandom_range(0, 1), $urandom_range(0, 2));
                tube_empty[i] = ($urandom_range(0, 29) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        fault_clr = 2'b11;
        tube_empty[0] = 4'b0000;
        tube_empty[1] = 4'b0000;
        wait_idle(0, 400);
        wait_idle(1, 400);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coin_eject_sequencer.md
Name: coin_eject_sequencer

Overview:
- Downstream stage of the change-making logic.
- Accepts one change vector (quarter, dime, nickel and penny counts) per vend through a valid/ready handshake.
- Drives the four coin-tube eject solenoids one coin at a time, largest denomination first, with programmable pulse width and inter-coin gap.
- Reports completion, a remaining-coin count, and an empty-tube fault that aborts the payout.

Parameters:
- PULSE_CYCLES, 4: solenoid on-time per coin in clk cycles (>=1).
- GAP_CYCLES, 2: mandatory off-time after each coin in clk cycles (>=1).
- CNT_W, 4: width of the pulse/gap timer (must hold max(PULSE_CYCLES, GAP_CYCLES)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  change vector valid.
- in_ready  out  1  block can accept a vector (high only in IDLE).
- quarters  in  4  quarters to dispense.
- dimes  in  3  dimes to dispense.
- nickels  in  3  nickels to dispense.
- pennies  in  3  pennies to dispense.
- tube_empty  in  4  per-tube empty sensor, bit 3 = quarter, 2 = dime, 1 = nickel, 0 = penny.
- fault_clr  in  1  clears FAULT state.
- eject  out  4  solenoid drives, same bit order as tube_empty; at most one bit high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a payout completes successfully.
- fault  out  1  held high in FAULT.
- fault_coin  out  2  denomination that faulted: 3 = quarter, 2 = dime, 1 = nickel, 0 = penny.
- coins_left  out  6  sum of remaining latched counts (max 15+7+7+7 = 36).

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; all latched counts 0.
  - eject=0, done=0, fault=0, fault_coin=0, coins_left=0, busy=0, in_ready=1.
  - A payout in progress is discarded; a solenoid drive drops immediately.
- All outputs are registered, except in_ready and busy, which decode the state directly.
- States: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge k, latch all four counts.
  - All counts zero: go to DONE (done pulses in cycle k+1, no eject).
  - Otherwise: go to SELECT.
  - in_valid while not in IDLE is ignored (no queueing).
- SELECT (1 cycle):
  - Choose the highest nonzero denomination: quarter > dime > nickel > penny.
  - If that tube's tube_empty bit is high (sampled this cycle): go to FAULT and set fault_coin.
  - Otherwise: load the timer and go to PULSE.
- PULSE: the chosen eject bit is high for exactly PULSE_CYCLES cycles. On the last PULSE cycle, decrement that count and coins_left by 1. Then go to GAP.
- GAP: eject=0 for exactly GAP_CYCLES cycles. Then go to DONE if coins_left==0, else SELECT.
- Per-coin period is 1+PULSE_CYCLES+GAP_CYCLES cycles. For N coins accepted at edge k, done is high in cycle k+1+N*(1+PULSE_CYCLES+GAP_CYCLES).
- DONE (1 cycle): done=1, then IDLE.
- FAULT:
  - fault=1, eject=0, remaining counts cleared, coins_left=0.
  - Held until fault_clr is sampled high; then IDLE on the next edge.
  - done is not asserted for an aborted payout.
  - fault_clr outside FAULT has no effect.
- tube_empty is sampled only in SELECT. A change during PULSE or GAP does not abort the current coin.
- Decrements never underflow: a denomination is selected only if its count is nonzero.
- Simultaneous fault_clr and in_valid in FAULT: only the clear is acted on. The vector may be accepted from IDLE on the following cycle.

Test Plan:
1. Accept 37c. Stimulus: quarters=1, dimes=1, nickels=0, pennies=2, PULSE=2, GAP=1, accept at edge 0. Required: eject=1000 in cycles 2-3, 0100 in 6-7, 0001 in 10-11 and 14-15; coins_left steps 4→3→2→1→0; done in cycle 17 only.
2. Zero change. Stimulus: all counts 0. Required: done in cycle 1, eject never asserted, busy high for one cycle.
3. Empty tube. Stimulus: quarters=2, dimes=1, tube_empty=0100 raised after the first quarter. Required: both quarters ejected; fault=1 and fault_coin=2 in the cycle after the second GAP ends; eject stays 0; done never asserted. Then pulse fault_clr: IDLE next edge, in_ready=1.
4. Max load. Stimulus: 15/7/7/7, default parameters. Required: 36 pulses in strict q→d→n→p order; coins_left=36 after accept; done exactly 1+36*7 cycles after accept; eject is never multi-hot.
5. Reset mid-payout. Stimulus: rst_n low during the PULSE of the 2nd coin. Required: eject drops to 0 asynchronously; all outputs return to reset values; a new vector is accepted normally after release.
6. Busy handshake. Stimulus: in_valid held high with a different vector throughout a payout. Required: in_ready=0 while busy; the second vector is accepted only in the first IDLE cycle after done.
